multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath; it is the producer of the ALU_op bus that ALU_Control decodes into ALU_Ctl.
- Sequences each instruction through fetch/decode/execute/memory/writeback steps from the 6-bit opcode.
- Drives all datapath mux selects and write strobes.
- Stalls on a memory-ready handshake and computes the PC enable from the ALU Zero_Flag.

Parameters:
STATE_W, 4, state register width; must be >= 4; unused high bits are held 0.

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Opcode  input  6  instruction[31:26], taken from the instruction register
Zero_Flag  input  1  ALU zero result
Mem_Ready  input  1  memory completes the current read/write this cycle
ALU_op  output  2  to ALU_Control: 00 add, 01 sub, 10 use FuncCode
ALUSrcA  output  1  0 = PC, 1 = reg A
ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load instruction register
MemtoReg  output  1  register-file write data: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination register: 0 = rt, 1 = rd
RegWrite  output  1  register-file write
PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
PC_En  output  1  PCWrite | (PCWriteCond & Zero_Flag)
Illegal_Op  output  1  one-cycle pulse on an unsupported opcode
State  output  STATE_W  current state, for debug

Behaviour:
- Moore FSM. All outputs are decoded combinationally from State. Exceptions: IRWrite, PC_En and the state advance in memory states are also qualified by Mem_Ready.
- Rst_n low (async): State = RESET (0). In RESET every output is 0, including ALU_op = 00 and PCSource = 00.
- RESET -> FETCH unconditionally on the next Clk.
- FETCH:
  - Outputs: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALU_op = 00, PCSource = 00.
  - IRWrite = Mem_Ready; PCWrite = Mem_Ready.
  - Stay in FETCH while Mem_Ready = 0; go to DECODE when Mem_Ready = 1.
- DECODE:
  - Outputs: ALUSrcA = 0, ALUSrcB = 11, ALU_op = 00 (branch target computed into ALUOut).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, with Illegal_Op = 1 for this cycle.
- MEM_ADDR:
  - Outputs: ALUSrcA = 1, ALUSrcB = 10, ALU_op = 00.
  - Next: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: MemRead = 1, IorD = 1. Hold until Mem_Ready = 1, then -> MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Next: FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1. Hold until Mem_Ready = 1, then -> FETCH.
- EXECUTE: ALUSrcA = 1, ALUSrcB = 00, ALU_op = 10. Next: R_WB.
- R_WB: RegWrite = 1, MemtoReg = 0, RegDst = 1. Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA = 1, ALUSrcB = 00, ALU_op = 01, PCSource = 01, PCWriteCond = 1.
  - PC_En = Zero_Flag. Next: FETCH.
- JUMP: PCSource = 10, PCWrite = 1 (PC_En = 1). Next: FETCH.
- Any undefined State encoding -> RESET on the next Clk, with all outputs 0.
- Memory strobes (MemRead/MemWrite) stay asserted for the entire stall. Write strobes fire exactly once per memory access.
- Opcode is sampled only in DECODE and MEM_ADDR; it must be stable from IRWrite until FETCH.
- Rst_n asserted mid-instruction, including during a stall, forces RESET immediately. No partial write occurs after reset assertion.
- Cycle counts with Mem_Ready tied 1: lw 5, sw 4, R-type 4, beq 3, j 3.

Optional Feature:
ADDI_SUPPORT_EN
- Defined: opcode 001000 (addi) in DECODE -> ADDI_EXEC, then ADDI_WB, then FETCH (4 cycles).
  - ADDI_EXEC: ALUSrcA = 1, ALUSrcB = 10, ALU_op = 00.
  - ADDI_WB: RegWrite = 1, MemtoReg = 0, RegDst = 0.
- Undefined: 001000 is illegal; DECODE -> FETCH with an Illegal_Op pulse. The ADDI states do not exist.

Test Plan:
- Reset/run: Rst_n = 0 for 3 Clk with Mem_Ready = 1 -> all outputs 0, State = 0. Release -> FETCH one cycle later with MemRead = 1, PC_En = 1, IRWrite = 1.
- lw with stall: Opcode = 100011, Mem_Ready low 2 cycles in FETCH and 3 cycles in MEM_READ -> MemRead held throughout; IRWrite = 1 once; RegWrite = 1 once with MemtoReg = 1; total 10 cycles.
- R-type: Opcode = 000000 -> EXECUTE shows ALU_op = 10, ALUSrcB = 00; R_WB shows RegWrite = 1, RegDst = 1; back in FETCH after 4 cycles.
- beq both ways: Opcode = 000100 with Zero_Flag = 1 -> PC_En = 1, PCSource = 01, ALU_op = 01. With Zero_Flag = 0 -> PC_En = 0.
- Illegal/addi: Opcode = 001000 -> Illegal_Op pulses 1 cycle and returns to FETCH without the macro. With ADDI_SUPPORT_EN -> ADDI_WB asserts RegWrite with RegDst = 0.
- Async reset mid-MEM_WRITE stall (MemWrite = 1) -> MemWrite drops 0 immediately, before any Clk edge.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle MIPS main controller (master) and the datapath (slave).
// Carries the opcode/flag/handshake inputs and every mux select and write strobe.
interface multicycle_control_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         Opcode;
    logic               Zero_Flag;
    logic               Mem_Ready;
    logic [1:0]         ALU_op;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic [1:0]         PCSource;
    logic               PC_En;
    logic               Illegal_Op;
    logic [STATE_W-1:0] State;

    modport master (
        input  Opcode, Zero_Flag, Mem_Ready,
        output ALU_op, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, PCSource, PC_En, Illegal_Op, State
    );

    modport slave (
        output Opcode, Zero_Flag, Mem_Ready,
        input  ALU_op, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, PCSource, PC_En, Illegal_Op, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Main Moore control FSM of the multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Optional macro ADDI_SUPPORT_EN adds the addi execute/writeback states.
module multicycle_control #(
    parameter int unsigned STATE_W = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    multicycle_control_if.master   ctl_io
);

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef ADDI_SUPPORT_EN
    localparam logic [5:0] OpAddi  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        StReset    = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecute  = 4'd7,
        StRWb      = 4'd8,
        StBranch   = 4'd9,
        StJump     = 4'd10
`ifdef ADDI_SUPPORT_EN
        ,
        StAddiExec = 4'd11,
        StAddiWb   = 4'd12
`endif
    } state_e;

    state_e state_q, state_d;
    logic   pc_write;
    logic   pc_write_cond;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StReset;
        case (state_q)
            StReset:    state_d = StFetch;
            StFetch:    state_d = ctl_io.Mem_Ready ? StDecode : StFetch;
            StDecode: begin
                case (ctl_io.Opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpRType:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
`ifdef ADDI_SUPPORT_EN
                    OpAddi:     state_d = StAddiExec;
`endif
                    default:    state_d = StFetch;
                endcase
            end
            StMemAddr: begin
                if (ctl_io.Opcode == OpLw) begin
                    state_d = StMemRead;
                end else if (ctl_io.Opcode == OpSw) begin
                    state_d = StMemWrite;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRead:  state_d = ctl_io.Mem_Ready ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = ctl_io.Mem_Ready ? StFetch : StMemWrite;
            StExecute:  state_d = StRWb;
            StRWb:      state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJump:     state_d = StFetch;
`ifdef ADDI_SUPPORT_EN
            StAddiExec: state_d = StAddiWb;
            StAddiWb:   state_d = StFetch;
`endif
            // Unused encodings recover through RESET.
            default:    state_d = StReset;
        endcase
    end

    always_comb begin
        ctl_io.ALU_op     = 2'b00;
        ctl_io.ALUSrcA    = 1'b0;
        ctl_io.ALUSrcB    = 2'b00;
        ctl_io.IorD       = 1'b0;
        ctl_io.MemRead    = 1'b0;
        ctl_io.MemWrite   = 1'b0;
        ctl_io.IRWrite    = 1'b0;
        ctl_io.MemtoReg   = 1'b0;
        ctl_io.RegDst     = 1'b0;
        ctl_io.RegWrite   = 1'b0;
        ctl_io.PCSource   = 2'b00;
        ctl_io.Illegal_Op = 1'b0;
        pc_write          = 1'b0;
        pc_write_cond     = 1'b0;
        case (state_q)
            StFetch: begin
                ctl_io.MemRead = 1'b1;
                ctl_io.ALUSrcB = 2'b01;
                // Instruction load and PC+4 commit only on the completing cycle.
                ctl_io.IRWrite = ctl_io.Mem_Ready;
                pc_write       = ctl_io.Mem_Ready;
            end
            StDecode: begin
                ctl_io.ALUSrcB = 2'b11;
                case (ctl_io.Opcode)
                    OpLw, OpSw, OpRType, OpBeq, OpJ: ctl_io.Illegal_Op = 1'b0;
`ifdef ADDI_SUPPORT_EN
                    OpAddi:  ctl_io.Illegal_Op = 1'b0;
`endif
                    default: ctl_io.Illegal_Op = 1'b1;
                endcase
            end
            StMemAddr: begin
                ctl_io.ALUSrcA = 1'b1;
                ctl_io.ALUSrcB = 2'b10;
            end
            StMemRead: begin
                ctl_io.MemRead = 1'b1;
                ctl_io.IorD    = 1'b1;
            end
            StMemWb: begin
                ctl_io.RegWrite = 1'b1;
                ctl_io.MemtoReg = 1'b1;
            end
            StMemWrite: begin
                ctl_io.MemWrite = 1'b1;
                ctl_io.IorD     = 1'b1;
            end
            StExecute: begin
                ctl_io.ALUSrcA = 1'b1;
                ctl_io.ALU_op  = 2'b10;
            end
            StRWb: begin
                ctl_io.RegWrite = 1'b1;
                ctl_io.RegDst   = 1'b1;
            end
            StBranch: begin
                ctl_io.ALUSrcA  = 1'b1;
                ctl_io.ALU_op   = 2'b01;
                ctl_io.PCSource = 2'b01;
                pc_write_cond   = 1'b1;
            end
            StJump: begin
                ctl_io.PCSource = 2'b10;
                pc_write        = 1'b1;
            end
`ifdef ADDI_SUPPORT_EN
            StAddiExec: begin
                ctl_io.ALUSrcA = 1'b1;
                ctl_io.ALUSrcB = 2'b10;
            end
            StAddiWb: begin
                ctl_io.RegWrite = 1'b1;
            end
`endif
            default: begin
                pc_write = 1'b0;
            end
        endcase
        ctl_io.PC_En = pc_write | (pc_write_cond & ctl_io.Zero_Flag);
        ctl_io.State = STATE_W'(state_q);
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: reset, R-type, lw with stalls, beq,
// j, illegal/addi opcode, sw and asynchronous reset during a write stall.
module tb_multicycle_control;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.STATE_W(4)) dut (
        .Clk    (clk),
        .Rst_n  (rst_n),
        .ctl_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] lw_st [10];
        logic       lw_rdy [10];
        int ir_cnt;
        int rw_cnt;
        int mr_cnt;
        int m2r_bad;

        lw_st  = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
        lw_rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;

        rst_n          = 1'b0;
        bus.Mem_Ready  = 1'b1;
        bus.Zero_Flag  = 1'b0;
        bus.Opcode     = 6'b000000;
        repeat (3) tick();
        chk("rst_state",   bus.State, 8'd0);
        chk("rst_memread", bus.MemRead, 8'd0);
        chk("rst_pc_en",   bus.PC_En, 8'd0);
        chk("rst_irwrite", bus.IRWrite, 8'd0);
        chk("rst_aluop",   bus.ALU_op, 8'd0);
        chk("rst_pcsrc",   bus.PCSource, 8'd0);
        chk("rst_alusrcb", bus.ALUSrcB, 8'd0);
        chk("rst_regwr",   bus.RegWrite, 8'd0);

        rst_n = 1'b1;
        tick();
        chk("fetch_state",   bus.State, 8'd1);
        chk("fetch_memread", bus.MemRead, 8'd1);
        chk("fetch_pc_en",   bus.PC_En, 8'd1);
        chk("fetch_irwrite", bus.IRWrite, 8'd1);
        chk("fetch_alusrcb", bus.ALUSrcB, 8'd1);
        chk("fetch_iord",    bus.IorD, 8'd0);

        // R-type
        bus.Opcode = 6'b000000;
        tick();
        chk("r_decode_state", bus.State, 8'd2);
        chk("r_decode_srcb",  bus.ALUSrcB, 8'd3);
        chk("r_decode_ill",   bus.Illegal_Op, 8'd0);
        tick();
        chk("r_exec_state", bus.State, 8'd7);
        chk("r_exec_aluop", bus.ALU_op, 8'd2);
        chk("r_exec_srcb",  bus.ALUSrcB, 8'd0);
        chk("r_exec_srca",  bus.ALUSrcA, 8'd1);
        tick();
        chk("r_wb_state",  bus.State, 8'd8);
        chk("r_wb_regwr",  bus.RegWrite, 8'd1);
        chk("r_wb_regdst", bus.RegDst, 8'd1);
        chk("r_wb_m2r",    bus.MemtoReg, 8'd0);
        tick();
        chk("r_back_fetch", bus.State, 8'd1);

        // lw with 2 fetch stall cycles and 3 read stall cycles
        bus.Opcode = 6'b100011;
        ir_cnt  = 0;
        rw_cnt  = 0;
        mr_cnt  = 0;
        m2r_bad = 0;
        for (int c = 0; c < 10; c++) begin
            bus.Mem_Ready = lw_rdy[c];
            #1;
            chk($sformatf("lw_state_c%0d", c), bus.State, 8'(lw_st[c]));
            ir_cnt += int'(bus.IRWrite);
            rw_cnt += int'(bus.RegWrite);
            mr_cnt += int'(bus.MemRead);
            if (bus.RegWrite && !bus.MemtoReg) m2r_bad++;
            if (c == 0) chk("lw_stall_pc_en", bus.PC_En, 8'd0);
            if (c == 6) chk("lw_read_iord", bus.IorD, 8'd1);
            tick();
        end
        chk("lw_irwrite_once", 8'(ir_cnt), 8'd1);
        chk("lw_regwrite_once", 8'(rw_cnt), 8'd1);
        chk("lw_memread_held", 8'(mr_cnt), 8'd7);
        chk("lw_memtoreg", 8'(m2r_bad), 8'd0);
        chk("lw_back_fetch", bus.State, 8'd1);
        bus.Mem_Ready = 1'b1;

        // beq both ways
        bus.Opcode = 6'b000100;
        tick();
        tick();
        chk("beq_state", bus.State, 8'd9);
        bus.Zero_Flag = 1'b1;
        #1;
        chk("beq_z1_pc_en", bus.PC_En, 8'd1);
        chk("beq_pcsrc",    bus.PCSource, 8'd1);
        chk("beq_aluop",    bus.ALU_op, 8'd1);
        chk("beq_srcb",     bus.ALUSrcB, 8'd0);
        bus.Zero_Flag = 1'b0;
        #1;
        chk("beq_z0_pc_en", bus.PC_En, 8'd0);
        tick();
        chk("beq_back_fetch", bus.State, 8'd1);

        // j
        bus.Opcode = 6'b000010;
        tick();
        tick();
        chk("j_state", bus.State, 8'd10);
        chk("j_pcsrc", bus.PCSource, 8'd2);
        chk("j_pc_en", bus.PC_En, 8'd1);
        tick();
        chk("j_back_fetch", bus.State, 8'd1);

        // addi: illegal unless the feature is built in
        bus.Opcode = 6'b001000;
        tick();
        chk("addi_decode", bus.State, 8'd2);
`ifdef ADDI_SUPPORT_EN
        chk("addi_ill", bus.Illegal_Op, 8'd0);
        tick();
        chk("addi_exec_state", bus.State, 8'd11);
        chk("addi_exec_srcb",  bus.ALUSrcB, 8'd2);
        tick();
        chk("addi_wb_state",  bus.State, 8'd12);
        chk("addi_wb_regwr",  bus.RegWrite, 8'd1);
        chk("addi_wb_regdst", bus.RegDst, 8'd0);
        tick();
`else
        chk("addi_ill", bus.Illegal_Op, 8'd1);
        tick();
`endif
        chk("addi_fetch", bus.State, 8'd1);
        chk("addi_ill_gone", bus.Illegal_Op, 8'd0);

        // Always-illegal opcode
        bus.Opcode = 6'b111111;
        tick();
        chk("ill_pulse", bus.Illegal_Op, 8'd1);
        tick();
        chk("ill_fetch", bus.State, 8'd1);

        // sw, stall in MEM_WRITE, then async reset
        bus.Opcode = 6'b101011;
        tick();
        tick();
        chk("sw_addr_state", bus.State, 8'd3);
        chk("sw_addr_srcb",  bus.ALUSrcB, 8'd2);
        chk("sw_addr_srca",  bus.ALUSrcA, 8'd1);
        bus.Mem_Ready = 1'b0;
        tick();
        chk("sw_write_state", bus.State, 8'd6);
        chk("sw_memwrite",    bus.MemWrite, 8'd1);
        tick();
        chk("sw_stall_memwrite", bus.MemWrite, 8'd1);
        chk("sw_stall_iord",     bus.IorD, 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_memwrite", bus.MemWrite, 8'd0);
        chk("async_rst_state",    bus.State, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
